// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM states and op classification helpers for the
// sequential multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
// work holds {acc, multiplier} for multiply and {remainder, dividend/quotient} for divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               mode_div_i,
    input  logic [2*WIDTH-1:0] work_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] work_o
);
    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] shl;
    logic [WIDTH:0] diff;

    always_comb begin
        add_sum = {1'b0, work_i[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i & {WIDTH{work_i[0]}}};
        shl     = work_i[2*WIDTH-1:WIDTH-1];
        diff    = shl - {1'b0, opnd_i};
        if (mode_div_i) begin
            // Top bit of diff set means the trial subtraction borrowed: restore.
            if (diff[WIDTH]) begin
                work_o = {shl[WIDTH-1:0], work_i[WIDTH-2:0], 1'b0};
            end else begin
                work_o = {diff[WIDTH-1:0], work_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            work_o = {add_sum, work_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit with architectural HI/LO.
// Signed ops run on magnitudes and fix the signs up in a final cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d, dbz_q, dbz_d;

    logic               is_div, a_neg, b_neg;
    logic [WIDTH-1:0]   a_raw, q_mag, r_mag;
    logic [2*WIDTH-1:0] prod, step_w;

    assign is_div = op_is_div(op_q);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_div_i (is_div),
        .work_i     (work_q),
        .opnd_i     (opnd_q),
        .work_o     (step_w)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;

        a_raw = work_q[WIDTH-1:0];
        a_neg = op_is_signed(op_q) & a_raw[WIDTH-1];
        b_neg = op_is_signed(op_q) & opnd_q[WIDTH-1];
        q_mag = work_q[WIDTH-1:0];
        r_mag = work_q[2*WIDTH-1:WIDTH];
        prod  = neg_res_q ? -work_q : work_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MTHI) begin
                        hi_d   = bus.a;
                        done_d = 1'b1;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d   = bus.a;
                        done_d = 1'b1;
                    end else if (!bus.op[2]) begin
                        op_d    = bus.op;
                        work_d  = {{WIDTH{1'b0}}, bus.a};
                        opnd_d  = bus.b;
                        state_d = ST_PREP;
                    end
                end
            end
            ST_PREP: begin
                neg_res_d = a_neg ^ b_neg;
                neg_rem_d = a_neg;
                work_d    = {{WIDTH{1'b0}}, (a_neg ? -a_raw : a_raw)};
                opnd_d    = b_neg ? -opnd_q : opnd_q;
                cnt_d     = '0;
                if (is_div && (opnd_q == '0)) begin
                    hi_d    = a_raw;
                    lo_d    = '1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                work_d = step_w;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div) begin
                    lo_d = neg_res_q ? -q_mag : q_mag;
                    hi_d = neg_rem_q ? -r_mag : r_mag;
                end else begin
                    {hi_d, lo_d} = prod;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // opnd_q holds |b| here, so zero means the divide was skipped.
                done_d  = 1'b1;
                dbz_d   = is_div && (opnd_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MULT;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    always_ff @(posedge clk) begin
        work_q <= work_d;
        opnd_q <= opnd_d;
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed checks on a 32-bit unit plus a randomised run of a 5-bit unit
// against an integer reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W  = 32;
    localparam int WS = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W))  bus ();
    muldiv_if #(.WIDTH(WS)) sbus ();

    muldiv_unit #(.WIDTH(W))  dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    muldiv_unit #(.WIDTH(WS)) dut5 (.clk(clk), .rst_n(rst_n), .bus(sbus));

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; edge 0 is the next posedge. lat = edges after edge 0 until done.
    task automatic run32(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int inj, input int bound, output int lat, output logic b0);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(negedge clk);
        bus.start = 1'b0;
        b0  = bus.busy;
        lat = 0;
        while (bus.done !== 1'b1 && lat < bound) begin
            if (lat == inj) begin
                bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd100; bus.b = 32'd7;
            end
            @(negedge clk);
            bus.start = 1'b0;
            lat++;
        end
    endtask

    task automatic run5(input logic [2:0] o, input logic [WS-1:0] x, input logic [WS-1:0] y,
                        output int lat);
        sbus.start = 1'b1; sbus.op = o; sbus.a = x; sbus.b = y;
        @(negedge clk);
        sbus.start = 1'b0;
        lat = 0;
        while (sbus.done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int          lat, elat, dcnt, sa, sb, p;
        logic        b0, mdbz;
        logic [2:0]  o;
        logic [WS-1:0] x, y, mhi, mlo;
        logic [2*WS-1:0] pw;

        bus.start  = 1'b0; bus.op  = '0; bus.a  = '0; bus.b  = '0;
        sbus.start = 1'b0; sbus.op = '0; sbus.a = '0; sbus.b = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_dbz",  bus.div_by_zero, 0);
        check_val("rst_hi",   bus.hi, 0);
        check_val("rst_lo",   bus.lo, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run32(OP_MULT, 32'hFFFF_FFF9, 32'd6, -1, 60, lat, b0);
        check_val("mult_busy",  b0, 1);
        check_val("mult_lat",   lat, 35);
        check_val("mult_nbusy", bus.busy, 0);
        check_val("mult_hi",    bus.hi, 32'hFFFF_FFFF);
        check_val("mult_lo",    bus.lo, 32'hFFFF_FFD6);
        check_val("mult_dbz",   bus.div_by_zero, 0);

        run32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 60, lat, b0);
        check_val("multu_lat", lat, 35);
        check_val("multu_hi",  bus.hi, 32'hFFFF_FFFE);
        check_val("multu_lo",  bus.lo, 32'h0000_0001);

        run32(OP_DIV, 32'hFFFF_FFEF, 32'd5, -1, 60, lat, b0);
        check_val("div_lat", lat, 35);
        check_val("div_lo",  bus.lo, 32'hFFFF_FFFD);
        check_val("div_hi",  bus.hi, 32'hFFFF_FFFE);

        run32(OP_DIVU, 32'd17, 32'd5, -1, 60, lat, b0);
        check_val("divu_lo", bus.lo, 32'd3);
        check_val("divu_hi", bus.hi, 32'd2);

        run32(OP_DIV, 32'd25, 32'd0, -1, 60, lat, b0);
        check_val("dbz_lat", lat, 2);
        check_val("dbz_flag", bus.div_by_zero, 1);
        check_val("dbz_lo",  bus.lo, 32'hFFFF_FFFF);
        check_val("dbz_hi",  bus.hi, 32'd25);
        @(negedge clk);
        check_val("dbz_done_pulse", bus.done, 0);
        check_val("dbz_flag_clr",   bus.div_by_zero, 0);
        check_val("dbz_hi_hold",    bus.hi, 32'd25);

        run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 60, lat, b0);
        check_val("minm1_lo",  bus.lo, 32'h8000_0000);
        check_val("minm1_hi",  bus.hi, 32'd0);
        check_val("minm1_dbz", bus.div_by_zero, 0);

        run32(OP_MULTU, 32'd3, 32'd4, 10, 60, lat, b0);
        check_val("inj_lat", lat, 35);
        check_val("inj_hi",  bus.hi, 32'd0);
        check_val("inj_lo",  bus.lo, 32'd12);

        run32(OP_MTHI, 32'h1234_5678, 32'd0, -1, 60, lat, b0);
        check_val("mthi_lat",  lat, 0);
        check_val("mthi_busy", b0, 0);
        check_val("mthi_hi",   bus.hi, 32'h1234_5678);
        check_val("mthi_lo",   bus.lo, 32'd12);

        run32(OP_MTLO, 32'hCAFE_BABE, 32'd0, -1, 60, lat, b0);
        check_val("mtlo_lat", lat, 0);
        check_val("mtlo_lo",  bus.lo, 32'hCAFE_BABE);
        check_val("mtlo_hi",  bus.hi, 32'h1234_5678);

        run32(3'b110, 32'd1, 32'd1, -1, 6, lat, b0);
        check_val("rsv_nodone", lat, 6);
        check_val("rsv_busy",   b0, 0);
        check_val("rsv_hi",     bus.hi, 32'h1234_5678);
        check_val("rsv_lo",     bus.lo, 32'hCAFE_BABE);

        bus.start = 1'b1; bus.op = OP_MULT; bus.a = 32'd9; bus.b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check_val("rstrun_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("rstrun_busy0", bus.busy, 0);
        check_val("rstrun_done0", bus.done, 0);
        check_val("rstrun_dbz0",  bus.div_by_zero, 0);
        check_val("rstrun_hi0",   bus.hi, 0);
        check_val("rstrun_lo0",   bus.lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        repeat (45) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        check_val("rstrun_nodone", dcnt, 0);
        check_val("rstrun_hi",     bus.hi, 0);
        check_val("rstrun_lo",     bus.lo, 0);

        mhi = '0;
        mlo = '0;
        for (int i = 0; i < 200; i++) begin
            o = 3'($urandom_range(0, 5));
            x = WS'($urandom);
            y = WS'($urandom);
            if (i % 17 == 3) y = '0;
            if (i % 23 == 5) begin o = OP_DIV; x = 5'b10000; y = 5'b11111; end
            mdbz = 1'b0;
            elat = WS + 3;
            case (o)
                OP_MULT: begin
                    sa = $signed(x); sb = $signed(y); p = sa * sb;
                    pw = p[2*WS-1:0]; {mhi, mlo} = pw;
                end
                OP_MULTU: begin
                    sa = x; sb = y; p = sa * sb;
                    pw = p[2*WS-1:0]; {mhi, mlo} = pw;
                end
                OP_DIV, OP_DIVU: begin
                    if (y == '0) begin
                        mhi = x; mlo = '1; mdbz = 1'b1; elat = 2;
                    end else begin
                        if (o == OP_DIV) begin sa = $signed(x); sb = $signed(y); end
                        else begin sa = x; sb = y; end
                        mlo = WS'(sa / sb);
                        mhi = WS'(sa % sb);
                    end
                end
                OP_MTHI: begin mhi = x; elat = 0; end
                default: begin mlo = x; elat = 0; end
            endcase
            run5(o, x, y, lat);
            check_val($sformatf("r%0d_lat", i), lat, elat);
            check_val($sformatf("r%0d_hi", i),  sbus.hi, mhi);
            check_val($sformatf("r%0d_lo", i),  sbus.lo, mlo);
            check_val($sformatf("r%0d_dbz", i), sbus.div_by_zero, mdbz);
        end

        run5(OP_MTHI, 5'h0A, 5'h00, lat);
        run5(OP_MTLO, 5'h15, 5'h00, lat);
        check_val("s_mt_hi", sbus.hi, 5'h0A);
        check_val("s_mt_lo", sbus.lo, 5'h15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
